// File: rtl/ide_host.sv
// IDE/ATA PIO host: programs LBA and command registers, streams one
// sector through the data register, then polls status until ready.
module ide_host #(
   parameter int SECTOR_BYTES  = 512,
   parameter int STROBE_CYCLES = 2,
   parameter int POLL_LIMIT    = 1024
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  logic        op,
   input  logic [23:0] lba,
   input  logic [7:0]  wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        ide_ce_n,
   output logic        ide_oe_n,
   output logic        ide_we_n,
   output logic [2:0]  ide_addr,
   output logic [7:0]  ide_dout,
   input  logic [7:0]  ide_din,
   output logic        ide_doe
);

   localparam int SW = $clog2(STROBE_CYCLES + 1);
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam logic [SW-1:0] S_LAST = SW'(STROBE_CYCLES - 1);
   localparam logic [PW-1:0] P_MAX  = PW'(POLL_LIMIT);
   localparam logic [9:0]    B_MAX  = 10'(SECTOR_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_LBA0, S_LBA1, S_LBA2, S_CMD, S_XFER, S_POLL, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      P_GAP, P_SETUP, P_STROBE, P_HOLD
   } phase_t;

   state_t        st_q;
   phase_t        ph_q;
   logic [SW-1:0] scnt_q;
   logic [9:0]    bcnt_q;
   logic [9:0]    bcnt_d;
   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;
   logic          op_q;
   logic [23:0]   lba_q;
   logic          acc_wr_q;
   logic [7:0]    rbuf_q;
   logic [7:0]    wbyte_q;
   logic          have_q;
   logic          ce_n_q, oe_n_q, we_n_q, doe_q;
   logic [2:0]    addr_q;
   logic [7:0]    dout_q;
   logic          busy_q, done_q, err_q;
   logic          wr_ready_q, rd_valid_q;
   logic [7:0]    rd_data_q;

   logic          go_d;
   logic          go_wr_d;
   logic [2:0]    go_addr_d;
   logic [7:0]    go_data_d;

   assign bcnt_d = bcnt_q + 10'd1;
   assign pcnt_d = pcnt_q + PW'(1);

   // Pick the next bus access the current state wants, if any
   always_comb begin
      go_d      = 1'b0;
      go_wr_d   = 1'b1;
      go_addr_d = 3'd0;
      go_data_d = 8'h00;
      unique case (st_q)
         S_LBA0: begin
            go_d      = 1'b1;
            go_addr_d = 3'd3;
            go_data_d = lba_q[7:0];
         end
         S_LBA1: begin
            go_d      = 1'b1;
            go_addr_d = 3'd4;
            go_data_d = lba_q[15:8];
         end
         S_LBA2: begin
            go_d      = 1'b1;
            go_addr_d = 3'd5;
            go_data_d = lba_q[23:16];
         end
         S_CMD: begin
            go_d      = 1'b1;
            go_addr_d = 3'd7;
            go_data_d = op_q ? 8'h30 : 8'h20;
         end
         S_XFER: begin
            if (op_q) begin
               go_d      = have_q;
               go_data_d = wbyte_q;
            end else begin
               go_wr_d = 1'b0;
               go_d    = !rd_valid_q && (bcnt_q != B_MAX);
            end
         end
         S_POLL: begin
            go_d      = 1'b1;
            go_wr_d   = 1'b0;
            go_addr_d = 3'd7;
         end
         default: ;
      endcase
   end

   // Control FSM and bus access sequencer with registered outputs
   always_ff @(posedge clk) begin
      if (arst) begin
         st_q       <= S_IDLE;
         ph_q       <= P_GAP;
         scnt_q     <= '0;
         bcnt_q     <= '0;
         pcnt_q     <= '0;
         op_q       <= 1'b0;
         lba_q      <= '0;
         acc_wr_q   <= 1'b0;
         rbuf_q     <= '0;
         wbyte_q    <= '0;
         have_q     <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         doe_q      <= 1'b0;
         addr_q     <= '0;
         dout_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (ph_q)
            P_SETUP: begin
               ph_q   <= P_STROBE;
               scnt_q <= '0;
               if (acc_wr_q) we_n_q <= 1'b0;
               else          oe_n_q <= 1'b0;
            end
            P_STROBE: begin
               if (scnt_q == S_LAST) begin
                  ph_q   <= P_HOLD;
                  oe_n_q <= 1'b1;
                  we_n_q <= 1'b1;
                  if (!acc_wr_q) rbuf_q <= ide_din;
               end else begin
                  scnt_q <= scnt_q + SW'(1);
               end
            end
            P_HOLD: begin
               ph_q   <= P_GAP;
               ce_n_q <= 1'b1;
               doe_q  <= 1'b0;
               unique case (st_q)
                  S_LBA0: st_q <= S_LBA1;
                  S_LBA1: st_q <= S_LBA2;
                  S_LBA2: st_q <= S_CMD;
                  S_CMD:  st_q <= S_XFER;
                  S_XFER: begin
                     bcnt_q <= bcnt_d;
                     if (op_q) begin
                        have_q <= 1'b0;
                     end else begin
                        rd_data_q  <= rbuf_q;
                        rd_valid_q <= 1'b1;
                     end
                  end
                  S_POLL: begin
                     pcnt_q <= pcnt_d;
                     if (!rbuf_q[3]) begin
                        st_q   <= S_DONE;
                        done_q <= 1'b1;
                     end else if (pcnt_d == P_MAX) begin
                        err_q  <= 1'b1;
                        st_q   <= S_DONE;
                        done_q <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            P_GAP: begin
               if (go_d) begin
                  ph_q     <= P_SETUP;
                  ce_n_q   <= 1'b0;
                  addr_q   <= go_addr_d;
                  dout_q   <= go_data_d;
                  doe_q    <= go_wr_d;
                  acc_wr_q <= go_wr_d;
               end
               unique case (st_q)
                  S_IDLE: begin
                     if (start) begin
                        st_q   <= S_LBA0;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        op_q   <= op;
                        lba_q  <= lba;
                        bcnt_q <= '0;
                        pcnt_q <= '0;
                     end
                  end
                  S_XFER: begin
                     if (op_q) begin
                        // wr_ready is raised only once wr_valid is seen,
                        // so it is a single-clock take pulse
                        if (wr_ready_q) begin
                           wr_ready_q <= 1'b0;
                           if (wr_valid) begin
                              wbyte_q <= wr_data;
                              have_q  <= 1'b1;
                           end
                        end else if (!have_q && bcnt_q != B_MAX) begin
                           if (wr_valid) wr_ready_q <= 1'b1;
                        end else if (!have_q) begin
                           st_q <= S_POLL;
                        end
                     end else begin
                        if (rd_valid_q) begin
                           if (rd_ready) rd_valid_q <= 1'b0;
                        end else if (bcnt_q == B_MAX) begin
                           st_q <= S_POLL;
                        end
                     end
                  end
                  S_DONE: begin
                     st_q   <= S_IDLE;
                     busy_q <= 1'b0;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign ide_ce_n = ce_n_q;
   assign ide_oe_n = oe_n_q;
   assign ide_we_n = we_n_q;
   assign ide_doe  = doe_q;
   assign ide_addr = addr_q;
   assign ide_dout = dout_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = err_q;
   assign wr_ready = wr_ready_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ide_host.sv
// Directed bench for ide_host with a small IDE device model
// (4-byte sectors, 3-clock strobes, 8-read poll limit).
module tb_ide_host;

   logic        clk = 1'b0;
   logic        arst;
   logic        start;
   logic        op;
   logic [23:0] lba;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        busy, done, error;
   logic        ide_ce_n, ide_oe_n, ide_we_n;
   logic [2:0]  ide_addr;
   logic [7:0]  ide_dout;
   logic [7:0]  ide_din;
   logic        ide_doe;

   int checks   = 0;
   int failures = 0;

   ide_host #(
      .SECTOR_BYTES (4),
      .STROBE_CYCLES(3),
      .POLL_LIMIT   (8)
   ) dut (
      .clk     (clk),
      .arst    (arst),
      .start   (start),
      .op      (op),
      .lba     (lba),
      .wr_data (wr_data),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .rd_ready(rd_ready),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .ide_ce_n(ide_ce_n),
      .ide_oe_n(ide_oe_n),
      .ide_we_n(ide_we_n),
      .ide_addr(ide_addr),
      .ide_dout(ide_dout),
      .ide_din (ide_din),
      .ide_doe (ide_doe)
   );

   always #5 clk = ~clk;

   // device model state
   logic [7:0]  dreg [8];
   logic [7:0]  rmem [4];
   logic [7:0]  wmem [4];
   int          rptr = 0;
   int          wptr = 0;
   logic        stuck = 1'b0;
   logic [7:0]  devq;
   logic [10:0] wlog [$];
   int          nreads = 0;
   int          nstat = 0;
   int          overlap = 0;
   int          badlen = 0;
   int          baddoe = 0;
   int          slo = 0;
   int          clo = 0;
   logic        pwe = 1'b1;
   logic        poe = 1'b1;

   always_comb begin
      devq = 8'h00;
      if (ide_addr == 3'd0)      devq = rmem[rptr[1:0]];
      else if (ide_addr == 3'd7) devq = stuck ? 8'h58 : 8'h50;
      else                       devq = dreg[ide_addr];
   end

   assign ide_din = (!ide_ce_n && !ide_oe_n) ? devq : 8'h00;

   // bus monitor: logs writes, counts reads, checks strobe timing
   always @(negedge clk) begin
      if (!ide_oe_n && !ide_we_n) overlap++;
      if (ide_ce_n && ide_doe) baddoe++;
      if (!ide_we_n && !ide_doe) baddoe++;
      if (!ide_oe_n && ide_doe) baddoe++;
      if (arst) begin
         slo = 0;
         clo = 0;
      end else begin
         if (!ide_oe_n || !ide_we_n) slo++;
         else if (slo != 0) begin
            if (slo != 3) badlen++;
            slo = 0;
         end
         if (ide_ce_n === 1'b0) clo++;
         else if (clo != 0) begin
            if (clo != 5) badlen++;
            clo = 0;
         end
      end
      if (!ide_we_n && pwe) begin
         wlog.push_back({ide_addr, ide_dout});
         dreg[ide_addr] = ide_dout;
         if (ide_addr == 3'd0) begin
            wmem[wptr[1:0]] = ide_dout;
            wptr++;
         end
      end
      if (!ide_oe_n && poe) begin
         nreads++;
         if (ide_addr == 3'd7) nstat++;
      end
      if (ide_oe_n && !poe && ide_addr == 3'd0) rptr++;
      pwe = ide_we_n;
      poe = ide_oe_n;
   end

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic start_op(input logic o, input logic [23:0] a);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      lba   = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done"}, done, 1);
      @(negedge clk);
      chk({tag, " done pulse/idle"}, {done, busy}, 2'b00);
   endtask

   task automatic get_byte(output logic [7:0] b);
      int n = 0;
      rd_ready = 1'b1;
      while (!rd_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("rd_valid seen", rd_valid, 1);
      b = rd_data;
      @(negedge clk);
   endtask

   logic [7:0] b0, b1, b2, b3;
   logic       stable;
   int         nr, gapbad, n;

   initial begin
      arst = 1'b1; start = 1'b0; op = 1'b0; lba = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      rmem[0] = 8'h11; rmem[1] = 8'h22; rmem[2] = 8'h33; rmem[3] = 8'h44;
      for (int i = 0; i < 8; i++) dreg[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset strobes", {ide_ce_n, ide_oe_n, ide_we_n, ide_doe},
          4'b1110);
      chk("reset bus", {ide_addr, ide_dout}, 11'h000);
      chk("reset status", {busy, done, error, wr_ready, rd_valid, rd_data},
          13'h0000);
      arst = 1'b0;

      // read sector with a 10-clock rd_ready stall on the first byte
      rptr = 0; nstat = 0; wlog.delete();
      start_op(1'b0, 24'h000100);
      n = 0;
      while (!rd_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("rd first valid", rd_valid, 1);
      b0 = rd_data;
      nr = nreads;
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (rd_data !== b0 || rd_valid !== 1'b1) stable = 1'b0;
      end
      chk("stall stable", stable, 1);
      chk("stall no strobe", nreads, nr);
      rd_ready = 1'b1;
      @(negedge clk);
      get_byte(b1);
      get_byte(b2);
      get_byte(b3);
      chk("rd data seq", {b0, b1, b2, b3}, 32'h11223344);
      wait_done("read");
      chk("read reg writes", {wlog[0], wlog[1], wlog[2], wlog[3]},
          {3'd3, 8'h00, 3'd4, 8'h01, 3'd5, 8'h00, 3'd7, 8'h20});
      chk("read wlog size", wlog.size(), 4);
      chk("read status polls", nstat, 1);
      chk("read error", error, 0);

      // write sector with wr_valid gaps
      wptr = 0; wlog.delete(); gapbad = 0;
      start_op(1'b1, 24'h123456);
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while ((wlog.size() != 4 + i || !ide_ce_n) && n < 3000) begin
            @(negedge clk);
            n++;
         end
         repeat (6) begin
            @(negedge clk);
            if (!ide_ce_n || wr_ready) gapbad++;
         end
         wr_valid = 1'b1;
         wr_data  = 8'hA0 + 8'(i);
         n = 0;
         while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("wr_ready seen", wr_ready, 1);
         @(negedge clk);
         wr_valid = 1'b0;
         chk("wr_ready pulse", wr_ready, 0);
      end
      wait_done("write");
      chk("write gaps idle", gapbad, 0);
      chk("write reg writes", {wlog[0], wlog[1], wlog[2], wlog[3]},
          {3'd3, 8'h56, 3'd4, 8'h34, 3'd5, 8'h12, 3'd7, 8'h30});
      chk("write data strobes", {wlog[4], wlog[5], wlog[6], wlog[7]},
          {3'd0, 8'hA0, 3'd0, 8'hA1, 3'd0, 8'hA2, 3'd0, 8'hA3});
      chk("write wlog size", wlog.size(), 8);
      chk("device memory", {wmem[0], wmem[1], wmem[2], wmem[3]},
          32'hA0A1A2A3);

      // status stuck busy -> poll timeout
      stuck = 1'b1; rptr = 0; nstat = 0;
      start_op(1'b0, 24'h000002);
      get_byte(b0); get_byte(b1); get_byte(b2); get_byte(b3);
      wait_done("timeout");
      chk("timeout polls", nstat, 8);
      chk("timeout error", error, 1);
      stuck = 1'b0; rptr = 0;
      start_op(1'b0, 24'h000003);
      chk("error cleared", {error, busy}, 2'b01);
      get_byte(b0); get_byte(b1); get_byte(b2); get_byte(b3);
      wait_done("after timeout");
      chk("after timeout error", error, 0);

      // reset in the middle of a strobe
      start_op(1'b0, 24'h000007);
      n = 0;
      while (ide_we_n && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort strobe seen", ide_we_n, 0);
      arst = 1'b1;
      @(negedge clk);
      chk("abort outputs", {ide_ce_n, ide_oe_n, ide_we_n, busy, ide_doe},
          5'b11100);
      @(negedge clk);
      arst = 1'b0;
      rptr = 0; wlog.delete();
      start_op(1'b0, 24'h000009);
      get_byte(b0); get_byte(b1); get_byte(b2); get_byte(b3);
      chk("post-reset data", {b0, b1, b2, b3}, 32'h11223344);
      wait_done("post-reset");
      chk("post-reset lba", wlog[0], {3'd3, 8'h09});

      chk("strobe overlap", overlap, 0);
      chk("access length", badlen, 0);
      chk("doe usage", baddoe, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ide_host.md
IDE_HOST -- requirements
Module: ide_host

Interface
REQ-001 SHALL have parameter SECTOR_BYTES, default 512, meaning bytes per transfer (range 1..512).
REQ-002 SHALL have parameter STROBE_CYCLES, default 2, meaning clocks oe_n/we_n are held low per access (>=1).
REQ-003 SHALL have parameter POLL_LIMIT, default 1024, meaning maximum status reads before timeout.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port arst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request pulse; accepted only while busy=0.
REQ-007 SHALL have port op  in  1  0=read sector (cmd 0x20), 1=write sector (cmd 0x30); sampled with start.
REQ-008 SHALL have port lba  in  24  sector address; sampled with start.
REQ-009 SHALL have port wr_data  in  8  write byte stream.
REQ-010 SHALL have port wr_valid / wr_ready  in / out  1  write-stream handshake; a byte moves when both are high.
REQ-011 SHALL have port rd_data  out  8  read byte stream.
REQ-012 SHALL have port rd_valid / rd_ready  out / in  1  read-stream handshake; rd_data is held stable while rd_valid=1 and rd_ready=0.
REQ-013 SHALL have port busy, done, error  out  1 each  busy=operation in progress; done=1-clk completion pulse; error=sticky timeout flag, cleared by the next accepted start.
REQ-014 SHALL have port ide_ce_n, ide_oe_n, ide_we_n  out  1 each  device strobes, active-low.
REQ-015 SHALL have port ide_addr  out  3  device register index.
REQ-016 SHALL have ports ide_dout  out  8  write data; ide_din  in  8  read data; ide_doe  out  1  enables ide_dout onto the data bus.

Function
REQ-017 Each bus access SHALL take STROBE_CYCLES+2 clocks: SETUP (ce_n=0, addr valid, both strobes high), STROBE (oe_n or we_n low for STROBE_CYCLES clocks), HOLD (strobes high, ce_n=0); ce_n returns to 1 in the following clock.
REQ-018 Read accesses SHALL register ide_din on the last STROBE clock; ide_doe SHALL be 1 from SETUP through HOLD of write accesses only; oe_n and we_n SHALL never be low together.
REQ-019 FSM states SHALL be IDLE, LBA0, LBA1, LBA2, CMD, XFER, POLL, DONE.
REQ-020 IDLE->LBA0 on start with busy=0; start while busy=1 SHALL be ignored.
REQ-021 LBA0/1/2 SHALL write reg 3 = lba[7:0], reg 4 = lba[15:8], reg 5 = lba[23:16], in that order.
REQ-022 CMD SHALL write reg 7 with 0x20 (op=0) or 0x30 (op=1), then go to XFER.
REQ-023 XFER read: each access to reg 0 yields one byte presented on rd_data with rd_valid=1; the next access SHALL NOT begin until that byte has been accepted (rd_ready stall).
REQ-024 XFER write: wr_ready SHALL pulse for 1 clk to take a byte; that byte SHALL then be written to reg 0; while wr_valid=0 the block waits with ce_n=1.
REQ-025 A 10-bit byte counter SHALL count accesses; XFER->POLL after exactly SECTOR_BYTES accesses.
REQ-026 POLL SHALL read reg 7 repeatedly; status bit 3 = 0 -> DONE; after POLL_LIMIT reads with bit 3 = 1, set error=1 -> DONE.
REQ-027 DONE SHALL pulse done for 1 clk, then go to IDLE; busy=1 in every state except IDLE.
REQ-028 A start accepted in the same clock that done pulses SHALL NOT be possible; done always precedes the IDLE clock.

Reset
REQ-029 arst=1 at a rising edge SHALL force IDLE, abort any access mid-cycle, and clear the counters.
REQ-030 Reset outputs: ce_n=oe_n=we_n=1, ide_addr=0, ide_dout=0, ide_doe=0, busy=0, done=0, error=0, wr_ready=0, rd_valid=0, rd_data=0.

Verification
REQ-031 Read, lba=0x000100, SECTOR_BYTES=4, device model pre-loaded with 0x11,0x22,0x33,0x44 -> writes 0x00,0x01,0x00 to regs 3,4,5; writes 0x20 to reg 7; rd_data sequence 0x11,0x22,0x33,0x44; one done pulse.
REQ-032 Write, 4 bytes 0xA0..0xA3 with wr_valid gaps -> 4 we_n strobes to reg 0 in order; ce_n stays 1 during gaps; device memory holds the bytes.
REQ-033 rd_ready held 0 for 10 clks after the first byte -> rd_data held stable; no further oe_n strobe until acceptance.
REQ-034 Status bit 3 stuck at 1, POLL_LIMIT=8 -> exactly 8 status reads, then error=1 and done pulse; the next start clears error.
REQ-035 arst asserted during a STROBE clock -> next clock all strobes high, busy=0; a subsequent start completes normally.
REQ-036 Every access, STROBE_CYCLES=3 -> strobe low exactly 3 clks, access length 5 clks, oe_n and we_n never low together.
